bp_fe_fetch_resp_buffer: RTL and testbench

- Sits directly downstream of the I$ wrapper and upstream of the fetch consumer (instruction queue or trace replay).
- The I$ produces data_v with no backpressure. This block therefore gates request issue to the I$ with credits, so every in-flight response is guaranteed a buffer slot.
- Buffers responses in order and presents them ready/valid (yumi) downstream.
- Handles flush by squashing responses that are already in flight, and tracks requests that end without data (miss or fault).

---
 rtl/bp_fe_pkg.sv | 12 +
 rtl/bp_fe_fetch_inflight_tracker.sv | 108 ++++++++++
 rtl/bp_fe_fetch_resp_buffer.sv | 111 +++++++++++
 tb/tb_bp_fe_fetch_resp_buffer.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/bp_fe_pkg.sv
// Front-end shared types.
//   bp_fe_fetch_buf_state_e : fetch response buffer control state
//     e_run    - responses are enqueued as they arrive
//     e_squash - responses belonging to flushed requests are discarded
package bp_fe_pkg;

  typedef enum logic {
    e_run    = 1'b0,
    e_squash = 1'b1
  } bp_fe_fetch_buf_state_e;

endpackage

// File: rtl/bp_fe_fetch_inflight_tracker.sv
// In-flight request tracker for the fetch response buffer.
// Owns the outstanding-request counter, the squash counter, the run/squash
// FSM and the credit calculation that gates new I$ requests.
//   clk_i, reset_i      clock, asynchronous active-low reset
//   issue_v_i           upstream fetch request valid
//   fetch_ready_i       I$ ready to accept a request
//   flush_i             discard everything currently in flight
//   resp_v_i            I$ returned data for the oldest request
//   resp_drop_i         oldest request ended without data
//   count_i             current buffer occupancy (registered, from parent)
//   issue_ready_o       upstream may issue
//   fetch_v_o           request valid towards the I$
//   enq_v_o             the response this cycle should be written
//   inflight_o          outstanding request count
//   proto_err_o         protocol violation seen this cycle
module bp_fe_fetch_inflight_tracker
  import bp_fe_pkg::*;
#(
  parameter int els_p          = 16,
  parameter int max_inflight_p = 2
) (
  input  logic                                  clk_i,
  input  logic                                  reset_i,
  input  logic                                  issue_v_i,
  input  logic                                  fetch_ready_i,
  input  logic                                  flush_i,
  input  logic                                  resp_v_i,
  input  logic                                  resp_drop_i,
  input  logic [$clog2(els_p+1)-1:0]            count_i,
  output logic                                  issue_ready_o,
  output logic                                  fetch_v_o,
  output logic                                  enq_v_o,
  output logic [$clog2(max_inflight_p+1)-1:0]   inflight_o,
  output logic                                  proto_err_o
);

  localparam int inflight_w_lp = $clog2(max_inflight_p+1);
  localparam int count_w_lp    = $clog2(els_p+1);
  localparam int occ_w_lp      = count_w_lp + 1;

  bp_fe_fetch_buf_state_e state_r, state_n;
  logic [inflight_w_lp-1:0] inflight_r, inflight_n;
  logic [inflight_w_lp-1:0] squash_r, squash_n, squash_flush;
  logic [occ_w_lp-1:0]      occ;
  logic credit, res, res_eff, issue_fire;

  // Credit uses registered occupancy only; a dequeue this cycle does not
  // free a slot until the next cycle.
  assign occ    = occ_w_lp'(count_i) + occ_w_lp'(inflight_r);
  assign credit = (occ < occ_w_lp'(els_p))
                & (inflight_r < inflight_w_lp'(max_inflight_p));

  assign issue_ready_o = fetch_ready_i & credit & ~flush_i;
  assign fetch_v_o     = issue_v_i & credit & ~flush_i;
  assign issue_fire    = issue_v_i & issue_ready_o;

  // Data and drop together count as one resolution; a resolution with
  // nothing outstanding is ignored so the counter saturates at zero.
  assign res     = resp_v_i | resp_drop_i;
  assign res_eff = res & (inflight_r != '0);

  assign proto_err_o = (resp_v_i & resp_drop_i) | (res & (inflight_r == '0));

  assign inflight_n   = inflight_r + inflight_w_lp'(issue_fire) - inflight_w_lp'(res_eff);
  assign squash_flush = inflight_r - inflight_w_lp'(res_eff);
  assign inflight_o   = inflight_r;

  always_comb begin
    state_n  = state_r;
    squash_n = squash_r;
    enq_v_o  = 1'b0;
    case (state_r)
      e_run: begin
        if (flush_i) begin
          squash_n = squash_flush;
          if (squash_flush != '0) state_n = e_squash;
        end else begin
          enq_v_o = resp_v_i;
        end
      end
      e_squash: begin
        // Squashed responses are always the oldest, so new issues made
        // here resolve only after the squash count drains.
        if (flush_i) begin
          squash_n = squash_flush;
          state_n  = (squash_flush != '0) ? e_squash : e_run;
        end else if (res) begin
          if (squash_r != '0) squash_n = squash_r - inflight_w_lp'(1);
          if (squash_r <= inflight_w_lp'(1)) state_n = e_run;
        end
      end
      default: state_n = e_run;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state_r    <= e_run;
      inflight_r <= '0;
      squash_r   <= '0;
    end else begin
      state_r    <= state_n;
      inflight_r <= inflight_n;
      squash_r   <= squash_n;
    end
  end

endmodule

// File: rtl/bp_fe_fetch_resp_buffer.sv
// Fetch response buffer between the I$ and the fetch consumer.
// Requests to the I$ are credit-gated so that every in-flight response has
// a guaranteed slot; responses are stored in order and offered downstream
// with valid/yumi. Flush squashes in-flight responses.
//   clk_i, reset_i   clock, asynchronous active-low reset
//   issue_v_i        upstream fetch request valid
//   issue_ready_o    upstream may issue
//   fetch_v_o        request valid to I$ (vaddr_v_i / ptag_v_i)
//   fetch_ready_i    I$ ready
//   resp_v_i         I$ data valid
//   resp_data_i      I$ data
//   resp_drop_i      oldest in-flight request ended without data
//   flush_i          discard buffer and all in-flight responses
//   data_o, v_o      head entry and its valid
//   yumi_i           consumer takes head
//   inflight_o       outstanding request count
//   error_o          sticky protocol error
module bp_fe_fetch_resp_buffer
  import bp_fe_pkg::*;
#(
  parameter int width_p        = 32,
  parameter int els_p          = 16,
  parameter int max_inflight_p = 2
) (
  input  logic                                 clk_i,
  input  logic                                 reset_i,
  input  logic                                 issue_v_i,
  output logic                                 issue_ready_o,
  output logic                                 fetch_v_o,
  input  logic                                 fetch_ready_i,
  input  logic                                 resp_v_i,
  input  logic [width_p-1:0]                   resp_data_i,
  input  logic                                 resp_drop_i,
  input  logic                                 flush_i,
  output logic [width_p-1:0]                   data_o,
  output logic                                 v_o,
  input  logic                                 yumi_i,
  output logic [$clog2(max_inflight_p+1)-1:0]  inflight_o,
  output logic                                 error_o
);

  localparam int ptr_w_lp   = (els_p > 1) ? $clog2(els_p) : 1;
  localparam int count_w_lp = $clog2(els_p+1);

  logic [width_p-1:0]    mem [els_p];
  logic [ptr_w_lp-1:0]   wptr_r, rptr_r;
  logic [count_w_lp-1:0] count_r, count_n;
  logic                  error_r;
  logic enq_req, enq, deq, full, trk_err, ovf_err, yumi_err;

  function automatic logic [ptr_w_lp-1:0] ptr_inc(input logic [ptr_w_lp-1:0] p);
    return (p == ptr_w_lp'(els_p-1)) ? '0 : p + ptr_w_lp'(1);
  endfunction

  bp_fe_fetch_inflight_tracker #(
    .els_p          (els_p),
    .max_inflight_p (max_inflight_p)
  ) u_tracker (
    .clk_i         (clk_i),
    .reset_i       (reset_i),
    .issue_v_i     (issue_v_i),
    .fetch_ready_i (fetch_ready_i),
    .flush_i       (flush_i),
    .resp_v_i      (resp_v_i),
    .resp_drop_i   (resp_drop_i),
    .count_i       (count_r),
    .issue_ready_o (issue_ready_o),
    .fetch_v_o     (fetch_v_o),
    .enq_v_o       (enq_req),
    .inflight_o    (inflight_o),
    .proto_err_o   (trk_err)
  );

  assign v_o    = (count_r != '0) & ~flush_i;
  assign data_o = mem[rptr_r];
  assign deq    = yumi_i & v_o;
  assign full   = (count_r == count_w_lp'(els_p));

  // A full buffer may still accept a write when the head leaves in the
  // same cycle; otherwise the write is dropped and flagged.
  assign enq      = enq_req & (~full | deq);
  assign ovf_err  = enq_req & full & ~deq;
  assign yumi_err = yumi_i & ~v_o & ~flush_i;
  assign count_n  = count_r + count_w_lp'(enq) - count_w_lp'(deq);
  assign error_o  = error_r;

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      wptr_r  <= '0;
      rptr_r  <= '0;
      count_r <= '0;
      error_r <= 1'b0;
    end else begin
      error_r <= error_r | trk_err | ovf_err | yumi_err;
      if (flush_i) begin
        wptr_r  <= '0;
        rptr_r  <= '0;
        count_r <= '0;
      end else begin
        if (enq) wptr_r <= ptr_inc(wptr_r);
        if (deq) rptr_r <= ptr_inc(rptr_r);
        count_r <= count_n;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (enq) mem[wptr_r] <= resp_data_i;
  end

endmodule

// File: tb/tb_bp_fe_fetch_resp_buffer.sv
module tb_bp_fe_fetch_resp_buffer;
  import bp_fe_pkg::*;

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic        issue_v_i, fetch_ready_i, resp_v_i, resp_drop_i, flush_i, yumi_i;
  logic [31:0] resp_data_i;
  logic        issue_ready_o, fetch_v_o, v_o, error_o;
  logic [31:0] data_o;
  logic [1:0]  inflight_o;

  int checks = 0;
  int failures = 0;

  // Reference model: buffer contents as a queue, plus outstanding and
  // squash counts.
  logic [31:0] m_q[$];
  int          m_inflight, m_squash;
  bit          m_err, m_fired;

  always #5 clk_i = ~clk_i;

  bp_fe_fetch_resp_buffer #(.width_p(32), .els_p(16), .max_inflight_p(2)) dut (
    .clk_i(clk_i), .reset_i(reset_i), .issue_v_i(issue_v_i), .issue_ready_o(issue_ready_o),
    .fetch_v_o(fetch_v_o), .fetch_ready_i(fetch_ready_i), .resp_v_i(resp_v_i),
    .resp_data_i(resp_data_i), .resp_drop_i(resp_drop_i), .flush_i(flush_i),
    .data_o(data_o), .v_o(v_o), .yumi_i(yumi_i), .inflight_o(inflight_o), .error_o(error_o)
  );

  function automatic bit m_credit();
    return ((m_q.size() + m_inflight) < 16) && (m_inflight < 2);
  endfunction

  task automatic model_reset();
    m_q.delete(); m_inflight = 0; m_squash = 0; m_err = 0; m_fired = 0;
  endtask

  task automatic model_step();
    bit res  = resp_v_i | resp_drop_i;
    bit fire = issue_v_i & fetch_ready_i & m_credit() & ~flush_i;
    bit deq  = yumi_i && (m_q.size() != 0) && !flush_i;
    if (resp_v_i && resp_drop_i) m_err = 1;
    if (yumi_i && !deq && !flush_i) m_err = 1;
    if (flush_i) begin
      m_q.delete();
      m_squash = (m_inflight > 0) ? m_inflight - int'(res) : 0;
    end else begin
      if (deq) void'(m_q.pop_front());
      if (m_squash > 0) begin
        if (res) m_squash--;
      end else if (resp_v_i) begin
        if (m_q.size() < 16) m_q.push_back(resp_data_i);
        else m_err = 1;
      end
    end
    if (res && m_inflight == 0) begin
      m_err = 1;
      m_inflight = int'(fire);
    end else begin
      m_inflight = m_inflight + int'(fire) - int'(res);
    end
    m_fired = fire;
  endtask

  task automatic cyc();
    model_step();
    @(posedge clk_i); #1;
  endtask

  task automatic idle_inputs();
    issue_v_i = 0; fetch_ready_i = 1; resp_v_i = 0; resp_drop_i = 0;
    flush_i = 0; yumi_i = 0; resp_data_i = '0;
  endtask

  task automatic test_reset();
    reset_i = 0; idle_inputs(); #2;
    checks++; if (v_o !== 1'b0) begin failures++; $display("FAIL reset_v_o got=%0b exp=0", v_o); end
    checks++; if (inflight_o !== 2'd0) begin failures++; $display("FAIL reset_inflight got=%0d exp=0", inflight_o); end
    checks++; if (error_o !== 1'b0) begin failures++; $display("FAIL reset_error got=%0b exp=0", error_o); end
    checks++; if (issue_ready_o !== 1'b1) begin failures++; $display("FAIL reset_ready_hi got=%0b exp=1", issue_ready_o); end
    fetch_ready_i = 0; #1;
    checks++; if (issue_ready_o !== 1'b0) begin failures++; $display("FAIL reset_ready_lo got=%0b exp=0", issue_ready_o); end
    @(posedge clk_i); #1;
    reset_i = 1; fetch_ready_i = 1; model_reset(); #1;
    checks++; if (issue_ready_o !== 1'b1) begin failures++; $display("FAIL reset_release_ready got=%0b exp=1", issue_ready_o); end
  endtask

  task automatic test_streaming();
    int fires = 0, outs = 0;
    bit pend = 0;
    for (int c = 0; c < 40; c++) begin
      issue_v_i = (fires < 16); fetch_ready_i = 1;
      resp_v_i = pend; resp_data_i = pend ? $urandom : 32'h0;
      yumi_i = (m_q.size() != 0);
      #1;
      checks++; if (issue_ready_o !== m_credit()) begin failures++; $display("FAIL stream_ready c=%0d got=%0b exp=%0b", c, issue_ready_o, m_credit()); end
      if (m_q.size() != 0) begin
        checks++; if (v_o !== 1'b1 || data_o !== m_q[0]) begin failures++; $display("FAIL stream_data c=%0d got=%0b/%h exp=1/%h", c, v_o, data_o, m_q[0]); end
        outs++;
      end else begin
        checks++; if (v_o !== 1'b0) begin failures++; $display("FAIL stream_v_idle c=%0d got=%0b exp=0", c, v_o); end
      end
      checks++; if (dut.count_r > 2) begin failures++; $display("FAIL stream_count c=%0d got=%0d exp<=2", c, dut.count_r); end
      cyc();
      if (m_fired) fires++;
      pend = m_fired;
    end
    checks++; if (outs != 16) begin failures++; $display("FAIL stream_outs got=%0d exp=16", outs); end
    checks++; if (error_o !== 1'b0) begin failures++; $display("FAIL stream_error got=%0b exp=0", error_o); end
    idle_inputs();
  endtask

  task automatic test_stall();
    int attempts = 0, dfires = 0;
    bit pend = 0;
    for (int c = 0; c < 30; c++) begin
      issue_v_i = (attempts < 20); if (issue_v_i) attempts++;
      yumi_i = 0; resp_v_i = pend; resp_data_i = $urandom;
      #1;
      checks++; if (issue_ready_o !== m_credit()) begin failures++; $display("FAIL stall_ready c=%0d got=%0b exp=%0b", c, issue_ready_o, m_credit()); end
      if (fetch_v_o && fetch_ready_i) dfires++;
      cyc();
      pend = m_fired;
    end
    checks++; if (dfires != 16) begin failures++; $display("FAIL stall_fires got=%0d exp=16", dfires); end
    issue_v_i = 0; resp_v_i = 0; yumi_i = 1; #1;
    checks++; if (v_o !== 1'b1 || data_o !== m_q[0] || issue_ready_o !== 1'b0) begin failures++; $display("FAIL stall_head got=%0b/%h/%0b exp=1/%h/0", v_o, data_o, issue_ready_o, m_q[0]); end
    cyc();
    yumi_i = 0; dfires = 0; pend = 0;
    for (int c = 0; c < 5; c++) begin
      issue_v_i = (c < 4); resp_v_i = pend; resp_data_i = $urandom;
      #1;
      if (fetch_v_o && fetch_ready_i) dfires++;
      cyc();
      pend = m_fired;
    end
    checks++; if (dfires != 1) begin failures++; $display("FAIL stall_release_fires got=%0d exp=1", dfires); end
    checks++; if (inflight_o !== 2'd0 || m_q.size() != 16) begin failures++; $display("FAIL stall_settle inflight=%0d exp=0 mq=%0d", inflight_o, m_q.size()); end
    idle_inputs(); flush_i = 1; #1;
    checks++; if (v_o !== 1'b0 || issue_ready_o !== 1'b0) begin failures++; $display("FAIL stall_flush_gate got=%0b/%0b exp=0/0", v_o, issue_ready_o); end
    cyc(); flush_i = 0;
  endtask

  task automatic test_flush_drop();
    idle_inputs(); issue_v_i = 1; #1;
    checks++; if (fetch_v_o !== 1'b1) begin failures++; $display("FAIL fd_fire0 got=%0b exp=1", fetch_v_o); end
    cyc(); #1;
    checks++; if (fetch_v_o !== 1'b1) begin failures++; $display("FAIL fd_fire1 got=%0b exp=1", fetch_v_o); end
    cyc();
    issue_v_i = 0; resp_v_i = 1; resp_data_i = 32'hDEAD0001; flush_i = 1; cyc();
    checks++; if (dut.u_tracker.squash_r !== 2'd1 || dut.u_tracker.state_r !== e_squash) begin failures++; $display("FAIL fd_squash got=%0d/%0d exp=1/1", dut.u_tracker.squash_r, dut.u_tracker.state_r); end
    checks++; if (inflight_o !== 2'd1) begin failures++; $display("FAIL fd_inflight got=%0d exp=1", inflight_o); end
    flush_i = 0; resp_data_i = 32'hDEAD0002; cyc();
    resp_v_i = 0; #1;
    checks++; if (v_o !== 1'b0) begin failures++; $display("FAIL fd_v got=%0b exp=0", v_o); end
    checks++; if (dut.u_tracker.state_r !== e_run || inflight_o !== 2'd0) begin failures++; $display("FAIL fd_state got=%0d/%0d exp=0/0", dut.u_tracker.state_r, inflight_o); end
    checks++; if (error_o !== 1'b0) begin failures++; $display("FAIL fd_error got=%0b exp=0", error_o); end
  endtask

  task automatic test_squash_new_issue();
    logic [31:0] b = $urandom;
    idle_inputs(); issue_v_i = 1; cyc();
    issue_v_i = 0; flush_i = 1; cyc();
    flush_i = 0; issue_v_i = 1; #1;
    checks++; if (issue_ready_o !== 1'b1) begin failures++; $display("FAIL sq_ready got=%0b exp=1", issue_ready_o); end
    cyc();
    issue_v_i = 0; resp_v_i = 1; resp_data_i = ~b; cyc();
    resp_data_i = b; #1;
    checks++; if (v_o !== 1'b0) begin failures++; $display("FAIL sq_old_dropped got=%0b exp=0", v_o); end
    cyc();
    resp_v_i = 0; #1;
    checks++; if (v_o !== 1'b1 || data_o !== b) begin failures++; $display("FAIL sq_new_out got=%0b/%h exp=1/%h", v_o, data_o, b); end
    yumi_i = 1; cyc(); yumi_i = 0; #1;
    checks++; if (v_o !== 1'b0 || inflight_o !== 2'd0) begin failures++; $display("FAIL sq_drained got=%0b/%0d exp=0/0", v_o, inflight_o); end
  endtask

  task automatic test_random();
    int pend[$];
    for (int c = 0; c < 420; c++) begin
      idle_inputs();
      if (c < 400) begin
        issue_v_i = 1'($urandom_range(0, 1));
        fetch_ready_i = ($urandom_range(0, 3) != 0);
        flush_i = ($urandom_range(0, 19) == 0);
      end
      if (pend.size() > 0 && pend[0] < c && $urandom_range(0, 3) != 0) begin
        void'(pend.pop_front());
        if ($urandom_range(0, 4) == 0) resp_drop_i = 1;
        else begin resp_v_i = 1; resp_data_i = $urandom; end
      end
      yumi_i = (m_q.size() != 0) && ($urandom_range(0, 1) == 1);
      #1;
      checks++; if (issue_ready_o !== (fetch_ready_i & m_credit() & ~flush_i)) begin failures++; $display("FAIL rnd_ready c=%0d got=%0b", c, issue_ready_o); end
      checks++; if (fetch_v_o !== (issue_v_i & m_credit() & ~flush_i)) begin failures++; $display("FAIL rnd_fetch_v c=%0d got=%0b", c, fetch_v_o); end
      checks++; if (v_o !== ((m_q.size() != 0) && !flush_i)) begin failures++; $display("FAIL rnd_v c=%0d got=%0b exp=%0d", c, v_o, m_q.size()); end
      if (m_q.size() != 0) begin
        checks++; if (data_o !== m_q[0]) begin failures++; $display("FAIL rnd_data c=%0d got=%h exp=%h", c, data_o, m_q[0]); end
      end
      checks++; if (inflight_o !== 2'(m_inflight)) begin failures++; $display("FAIL rnd_inflight c=%0d got=%0d exp=%0d", c, inflight_o, m_inflight); end
      checks++; if (error_o !== m_err) begin failures++; $display("FAIL rnd_error c=%0d got=%0b exp=%0b", c, error_o, m_err); end
      cyc();
      if (m_fired) pend.push_back(c);
    end
    checks++; if (pend.size() != 0 || inflight_o !== 2'd0) begin failures++; $display("FAIL rnd_drain pend=%0d inflight=%0d exp=0", pend.size(), inflight_o); end
  endtask

  task automatic test_drop_error();
    idle_inputs(); flush_i = 1; cyc();
    flush_i = 0; issue_v_i = 1; cyc();
    checks++; if (inflight_o !== 2'd1) begin failures++; $display("FAIL drop_inflight1 got=%0d exp=1", inflight_o); end
    issue_v_i = 0; resp_drop_i = 1; cyc();
    resp_drop_i = 0; #1;
    checks++; if (inflight_o !== 2'd0 || v_o !== 1'b0) begin failures++; $display("FAIL drop_resolved got=%0d/%0b exp=0/0", inflight_o, v_o); end
    checks++; if (issue_ready_o !== 1'b1 || error_o !== 1'b0) begin failures++; $display("FAIL drop_credit got=%0b/%0b exp=1/0", issue_ready_o, error_o); end
    resp_v_i = 1; resp_data_i = $urandom; cyc();
    resp_v_i = 0;
    for (int k = 0; k < 4; k++) begin
      #1;
      checks++; if (error_o !== 1'b1) begin failures++; $display("FAIL err_sticky k=%0d got=%0b exp=1", k, error_o); end
      cyc();
    end
  endtask

  task automatic test_async_reset();
    int pend[$];
    bit reached = 0;
    idle_inputs();
    for (int c = 0; c < 40 && !reached; c++) begin
      issue_v_i = 1; resp_v_i = 0;
      if (pend.size() > 0 && pend[0] < c && m_q.size() < 5) begin
        void'(pend.pop_front()); resp_v_i = 1; resp_data_i = $urandom;
      end
      #1; cyc();
      if (m_fired) pend.push_back(c);
      reached = (m_q.size() == 5) && (m_inflight == 2);
    end
    issue_v_i = 0; resp_v_i = 0; #1;
    checks++; if (!reached || dut.count_r !== 5'd5 || inflight_o !== 2'd2) begin failures++; $display("FAIL ar_setup count=%0d inflight=%0d exp=5/2", dut.count_r, inflight_o); end
    #2; reset_i = 0; #1;
    checks++; if (v_o !== 1'b0 || inflight_o !== 2'd0 || error_o !== 1'b0) begin failures++; $display("FAIL ar_outputs got=%0b/%0d/%0b exp=0/0/0", v_o, inflight_o, error_o); end
    checks++; if (dut.count_r !== 5'd0 || dut.u_tracker.squash_r !== 2'd0) begin failures++; $display("FAIL ar_counters got=%0d/%0d exp=0/0", dut.count_r, dut.u_tracker.squash_r); end
    fetch_ready_i = 0; #1;
    checks++; if (issue_ready_o !== 1'b0) begin failures++; $display("FAIL ar_ready_lo got=%0b exp=0", issue_ready_o); end
    fetch_ready_i = 1; #1;
    checks++; if (issue_ready_o !== 1'b1) begin failures++; $display("FAIL ar_ready_hi got=%0b exp=1", issue_ready_o); end
    @(posedge clk_i); #1;
    reset_i = 1; model_reset(); #1;
    checks++; if (issue_ready_o !== 1'b1 || v_o !== 1'b0) begin failures++; $display("FAIL ar_release got=%0b/%0b exp=1/0", issue_ready_o, v_o); end
    cyc();
  endtask

  initial begin
    model_reset();
    test_reset();
    test_streaming();
    test_stall();
    test_flush_drop();
    test_squash_new_issue();
    test_random();
    test_drop_error();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not complete in time");
    $fatal(1);
  end

endmodule
